tape_cell_ctrl: RTL and testbench

- Read-modify-write sequencer for the BeeF data tape; drives the increment/decrement arithmetic and owns the data pointer.
- Accepts decoded tape commands from the control unit over a valid/ready handshake and issues reads/writes to the single-port data memory.
- Caches the current cell so consecutive INC/DEC on the same cell skip the read.
- Exports the cell value and a zero flag for bracket branching.

---
 rtl/tape_cell_ctrl_if.sv | 32 +++
 rtl/tape_cell_ctrl.sv | 130 +++++++++++++
 tb/tb_tape_cell_ctrl.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/tape_cell_ctrl_if.sv
// Command and data-memory bundle for the BeeF tape-cell controller.
// slave: the controller side; master: control unit plus data memory.
interface tape_cell_ctrl_if #(
  parameter int unsigned PTR_W  = 8,
  parameter int unsigned DATA_W = 8
);
  logic              cmd_valid_i;
  logic              cmd_ready_o;
  logic [2:0]        cmd_op_i;
  logic [7:0]        cmd_arg_i;
  logic [PTR_W-1:0]  mem_addr_o;
  logic              mem_rd_en_o;
  logic [DATA_W-1:0] mem_rdata_i;
  logic              mem_wr_en_o;
  logic [DATA_W-1:0] mem_wdata_o;
  logic [PTR_W-1:0]  ptr_o;
  logic [DATA_W-1:0] cell_o;
  logic              cell_valid_o;
  logic              zero_o;

  modport slave (
    input  cmd_valid_i, cmd_op_i, cmd_arg_i, mem_rdata_i,
    output cmd_ready_o, mem_addr_o, mem_rd_en_o, mem_wr_en_o, mem_wdata_o,
           ptr_o, cell_o, cell_valid_o, zero_o
  );

  modport master (
    output cmd_valid_i, cmd_op_i, cmd_arg_i, mem_rdata_i,
    input  cmd_ready_o, mem_addr_o, mem_rd_en_o, mem_wr_en_o, mem_wdata_o,
           ptr_o, cell_o, cell_valid_o, zero_o
  );
endinterface

// File: rtl/tape_cell_ctrl.sv
// Read-modify-write sequencer for the BeeF data tape: owns the data pointer,
// caches the current cell and issues single-port memory reads/writes.
module tape_cell_ctrl #(
  parameter int unsigned PTR_W  = 8,
  parameter int unsigned DATA_W = 8
) (
  input  logic            clk,
  input  logic            reset,
  tape_cell_ctrl_if.slave bus
);

  localparam logic [2:0] OP_INC   = 3'd0;
  localparam logic [2:0] OP_DEC   = 3'd1;
  localparam logic [2:0] OP_LEFT  = 3'd2;
  localparam logic [2:0] OP_RIGHT = 3'd3;
  localparam logic [2:0] OP_SET   = 3'd4;
  localparam logic [2:0] OP_PEEK  = 3'd5;

  typedef enum logic [1:0] {S_IDLE, S_RD, S_WAIT, S_WR} state_e;

  state_e            state_q;
  logic [PTR_W-1:0]  ptr_q;
  logic [DATA_W-1:0] cell_q;
  logic              cell_valid_q;
  logic              ready_q;
  logic              rd_en_q;
  logic              wr_en_q;
  logic [2:0]        op_q;
  logic [7:0]        arg_q;

  function automatic logic [DATA_W-1:0] apply_arith(input logic [DATA_W-1:0] base,
                                                    input logic [2:0]        op,
                                                    input logic [7:0]        cnt);
    apply_arith = (op == OP_DEC) ? base - DATA_W'(cnt) : base + DATA_W'(cnt);
  endfunction

  // Strobes and ready are registered alongside the state they describe.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      ptr_q        <= '0;
      cell_q       <= '0;
      cell_valid_q <= 1'b0;
      ready_q      <= 1'b1;
      rd_en_q      <= 1'b0;
      wr_en_q      <= 1'b0;
      op_q         <= 3'd7;
      arg_q        <= '0;
    end else begin
      rd_en_q <= 1'b0;
      wr_en_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (bus.cmd_valid_i) begin
            op_q  <= bus.cmd_op_i;
            arg_q <= bus.cmd_arg_i;
            case (bus.cmd_op_i)
              OP_INC, OP_DEC: begin
                if (bus.cmd_arg_i != 8'd0) begin
                  ready_q <= 1'b0;
                  if (cell_valid_q) begin
                    cell_q  <= apply_arith(cell_q, bus.cmd_op_i, bus.cmd_arg_i);
                    wr_en_q <= 1'b1;
                    state_q <= S_WR;
                  end else begin
                    rd_en_q <= 1'b1;
                    state_q <= S_RD;
                  end
                end
              end
              OP_LEFT, OP_RIGHT: begin
                if (bus.cmd_arg_i != 8'd0) begin
                  ptr_q        <= (bus.cmd_op_i == OP_LEFT) ? ptr_q - PTR_W'(bus.cmd_arg_i)
                                                            : ptr_q + PTR_W'(bus.cmd_arg_i);
                  cell_valid_q <= 1'b0;
                end
              end
              OP_SET: begin
                cell_q       <= DATA_W'(bus.cmd_arg_i);
                cell_valid_q <= 1'b1;
                ready_q      <= 1'b0;
                wr_en_q      <= 1'b1;
                state_q      <= S_WR;
              end
              OP_PEEK: begin
                if (!cell_valid_q) begin
                  ready_q <= 1'b0;
                  rd_en_q <= 1'b1;
                  state_q <= S_RD;
                end
              end
              default: ;
            endcase
          end
        end
        S_RD: begin
          state_q <= S_WAIT;
        end
        S_WAIT: begin
          cell_valid_q <= 1'b1;
          if (op_q == OP_PEEK) begin
            cell_q  <= bus.mem_rdata_i;
            ready_q <= 1'b1;
            state_q <= S_IDLE;
          end else begin
            cell_q  <= apply_arith(bus.mem_rdata_i, op_q, arg_q);
            wr_en_q <= 1'b1;
            state_q <= S_WR;
          end
        end
        S_WR: begin
          ready_q <= 1'b1;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.cmd_ready_o  = ready_q;
  assign bus.mem_addr_o   = ptr_q;
  assign bus.mem_rd_en_o  = rd_en_q;
  assign bus.mem_wr_en_o  = wr_en_q;
  assign bus.mem_wdata_o  = cell_q;
  assign bus.ptr_o        = ptr_q;
  assign bus.cell_o       = cell_q;
  assign bus.cell_valid_o = cell_valid_q;
  assign bus.zero_o       = cell_valid_q && (cell_q == '0);

endmodule

// File: tb/tb_tape_cell_ctrl.sv
// Randomized bench for tape_cell_ctrl against a command-level tape model
// (pointer, cached cell and memory image updated per accepted command).
module tb_tape_cell_ctrl;

  localparam int OP_INC = 0, OP_DEC = 1, OP_LEFT = 2, OP_RIGHT = 3,
                 OP_SET = 4, OP_PEEK = 5, OP_NOP = 7;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  tape_cell_ctrl_if #(.PTR_W(8), .DATA_W(8)) bus ();

  tape_cell_ctrl #(.PTR_W(8), .DATA_W(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Data memory seen by the DUT: registered read, one-cycle write.
  logic [7:0] mem [256];
  always @(posedge clk) begin
    if (bus.mem_wr_en_o) mem[bus.mem_addr_o] <= bus.mem_wdata_o;
    bus.mem_rdata_i <= mem[bus.mem_addr_o];
  end

  // Reference tape state.
  int ref_mem [256];
  int ref_ptr, ref_cell;
  bit ref_valid;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input int obs, input int exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", tag, obs, obs, exp, exp, $time);
    end
  endtask

  task automatic chk_state(input string tag);
    chk({tag, "_ptr"}, int'(bus.ptr_o), ref_ptr);
    chk({tag, "_valid"}, int'(bus.cell_valid_o), int'(ref_valid));
    chk({tag, "_zero"}, int'(bus.zero_o), int'(ref_valid && ref_cell == 0));
    if (ref_valid) chk({tag, "_cell"}, int'(bus.cell_o), ref_cell);
  endtask

  task automatic do_cmd(input int op, input int arg);
    int lat_exp, rd_exp, wr_exp, wval_exp, addr_exp;
    int lat, rd_n, wr_n;
    bit done;
    lat_exp = 1; rd_exp = 0; wr_exp = 0; wval_exp = 0;
    addr_exp = ref_ptr;

    @(negedge clk);
    chk("ready_before_cmd", int'(bus.cmd_ready_o), 1);
    bus.cmd_valid_i = 1'b1;
    bus.cmd_op_i    = 3'(op);
    bus.cmd_arg_i   = 8'(arg);
    @(posedge clk);

    // Command-level model of the accepted command.
    case (op)
      OP_INC, OP_DEC: if (arg != 0) begin
        int base;
        base     = ref_valid ? ref_cell : ref_mem[ref_ptr];
        rd_exp   = ref_valid ? 0 : 1;
        lat_exp  = ref_valid ? 2 : 4;
        ref_cell = (op == OP_INC) ? (base + arg) % 256 : (base - arg + 256) % 256;
        ref_valid = 1'b1;
        wr_exp   = 1;
        wval_exp = ref_cell;
        ref_mem[ref_ptr] = ref_cell;
      end
      OP_LEFT, OP_RIGHT: if (arg != 0) begin
        ref_ptr   = (op == OP_RIGHT) ? (ref_ptr + arg) % 256 : (ref_ptr - arg + 256) % 256;
        ref_valid = 1'b0;
      end
      OP_SET: begin
        ref_cell  = arg;
        ref_valid = 1'b1;
        wr_exp    = 1;
        wval_exp  = arg;
        lat_exp   = 2;
        ref_mem[ref_ptr] = arg;
      end
      OP_PEEK: if (!ref_valid) begin
        ref_cell  = ref_mem[ref_ptr];
        ref_valid = 1'b1;
        rd_exp    = 1;
        lat_exp   = 3;
      end
      default: ;
    endcase

    lat = 0; rd_n = 0; wr_n = 0; done = 1'b0;
    @(negedge clk);
    while (!done && lat < 20) begin
      lat++;
      if (bus.mem_rd_en_o) begin
        rd_n++;
        chk("rd_addr", int'(bus.mem_addr_o), addr_exp);
      end
      if (bus.mem_wr_en_o) begin
        wr_n++;
        chk("wr_addr", int'(bus.mem_addr_o), addr_exp);
        chk("wr_data", int'(bus.mem_wdata_o), wval_exp);
      end
      if (bus.mem_rd_en_o && bus.mem_wr_en_o) chk("strobe_overlap", 1, 0);
      if (bus.cmd_ready_o) begin
        done = 1'b1;
        bus.cmd_valid_i = 1'b0;
      end else begin
        // Junk on the command port while busy must be ignored.
        bus.cmd_valid_i = 1'($urandom);
        bus.cmd_op_i    = 3'($urandom);
        bus.cmd_arg_i   = 8'($urandom);
        @(negedge clk);
      end
    end
    if (!done) chk("ready_timeout", 0, 1);
    bus.cmd_valid_i = 1'b0;
    chk("latency", lat, lat_exp);
    chk("rd_count", rd_n, rd_exp);
    chk("wr_count", wr_n, wr_exp);
    chk_state("post");
    chk("mem_cell", int'(mem[addr_exp]), ref_mem[addr_exp]);
  endtask

  task automatic reset_mid_inc();
    int wr_n = 0;
    int p;
    p = ref_ptr;
    @(negedge clk);
    bus.cmd_valid_i = 1'b1;
    bus.cmd_op_i    = 3'(OP_INC);
    bus.cmd_arg_i   = 8'd1;
    @(posedge clk);
    @(negedge clk);
    bus.cmd_valid_i = 1'b0;
    chk("rst_mid_rd", int'(bus.mem_rd_en_o), 1);
    @(negedge clk);
    if (bus.mem_wr_en_o) wr_n++;
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_mid_rd_en", int'(bus.mem_rd_en_o), 0);
    chk("rst_mid_wr_en", int'(bus.mem_wr_en_o), 0);
    chk("rst_mid_ptr", int'(bus.ptr_o), 0);
    chk("rst_mid_valid", int'(bus.cell_valid_o), 0);
    chk("rst_mid_ready", int'(bus.cmd_ready_o), 1);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (bus.mem_wr_en_o) wr_n++;
      @(negedge clk);
    end
    chk("rst_mid_no_write", wr_n, 0);
    chk("rst_mid_mem", int'(mem[p]), ref_mem[p]);
    ref_ptr = 0; ref_cell = 0; ref_valid = 1'b0;
  endtask

  initial begin
    reset           = 1'b1;
    bus.cmd_valid_i = 1'b0;
    bus.cmd_op_i    = 3'd7;
    bus.cmd_arg_i   = 8'd0;
    for (int i = 0; i < 256; i++) begin
      mem[i]     = 8'($urandom);
      ref_mem[i] = int'(mem[i]);
    end
    mem[0] = 8'hFF; ref_mem[0] = 255;
    ref_ptr = 0; ref_cell = 0; ref_valid = 1'b0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", int'(bus.cmd_ready_o), 1);
    chk("rst_rd_en", int'(bus.mem_rd_en_o), 0);
    chk("rst_wr_en", int'(bus.mem_wr_en_o), 0);
    chk("rst_cell", int'(bus.cell_o), 0);
    chk_state("rst");
    reset = 1'b0;

    // Directed scenarios.
    do_cmd(OP_INC, 1);
    do_cmd(OP_INC, 3);
    do_cmd(OP_LEFT, 1);
    mem[255] = 8'h00; ref_mem[255] = 0;
    do_cmd(OP_PEEK, 0);
    do_cmd(OP_SET, 8'h41);
    do_cmd(OP_DEC, 8'h42);
    do_cmd(OP_INC, 0);
    do_cmd(OP_NOP, 8'h5A);
    do_cmd(OP_RIGHT, 6);
    reset_mid_inc();

    // Randomized traffic.
    for (int n = 0; n < 400; n++) begin
      int op, arg;
      op  = int'($urandom_range(0, 7));
      arg = ($urandom_range(0, 7) == 0) ? 0
          : ($urandom_range(0, 1) == 0) ? int'($urandom_range(1, 4)) : int'($urandom_range(0, 255));
      do_cmd(op, arg);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
